mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, wait cycles between accept and first data beat (0 legal).
REQ-002 SHALL have parameter BURST, default 4, beats per line transfer (power of two, 1..16).
REQ-003 SHALL have parameter DEPTH, default 64, RAM size in 32-bit words (power of two).
REQ-004 Port: clk  input  1  the single clock; all logic on posedge.
REQ-005 Port: reset  input  1  reset, synchronous and active-high.
REQ-006 Port: req  input  1  cache requests a line transfer; held until ack.
REQ-007 Port: we  input  1  1 = writeback (cache to RAM), 0 = line fill; qualified by req.
REQ-008 Port: addr  input  32  byte address of the line.
REQ-009 Port: wdata  input  32  writeback beat data, valid while wready.
REQ-010 Port: ack  output  1  one-cycle pulse: request accepted.
REQ-011 Port: rvalid  output  1  fill beat valid on rdata.
REQ-012 Port: rdata  output  32  fill beat data.
REQ-013 Port: wready  output  1  current wdata beat consumed at the end of this cycle.
REQ-014 Port: done  output  1  one-cycle pulse: transfer complete.
REQ-015 Port: busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM IDLE, WAIT, XFER, DONE; all outputs registered.
REQ-017 IDLE: req sampled high at a posedge SHALL latch we and base index, then enter WAIT (LATENCY>0) or XFER (LATENCY=0).
REQ-018 Cycle 0 = first cycle after the accepting edge; ack SHALL be high in cycle 0 only.
REQ-019 WAIT SHALL occupy cycles 0..LATENCY-1; a down-counter loaded with LATENCY-1 ends it at zero.
REQ-020 XFER SHALL occupy cycles LATENCY..LATENCY+BURST-1, one beat per cycle, beat k at word index base+k.
REQ-021 Base index SHALL be addr[31:2] with the low log2(BURST) bits cleared; index SHALL wrap modulo DEPTH.
REQ-022 Fill: rvalid high exactly in XFER cycles; rdata = RAM[base+k] in beat k; rdata = 0 when rvalid low.
REQ-023 Writeback: wready high exactly in XFER cycles; RAM[base+k] <= wdata at the end of beat k.
REQ-024 DONE SHALL last one cycle (cycle LATENCY+BURST) with done high, then return to IDLE.
REQ-025 req, we, addr SHALL be ignored outside IDLE; a req held through DONE is accepted in the following IDLE cycle (minimum one IDLE cycle between transfers).
REQ-026 Fill beats SHALL not modify RAM; writeback beats SHALL not drive rvalid.

Reset
REQ-027 reset SHALL force IDLE and ack, rvalid, wready, done, busy = 0, rdata = 0 at the next posedge, overriding any state.
REQ-028 Reset mid-transfer SHALL abort: already written beats remain, remaining beats are never written.
REQ-029 The RAM array SHALL not be reset; it SHALL be a word-indexed array named RAM, preloadable by hierarchical reference from the bench.

Structure
REQ-030 The state enum and default LATENCY/BURST/DEPTH SHALL live in shared package mem_pkg.
REQ-031 No sub-module; FSM, counters and RAM in one module.

Verification (LATENCY=4, BURST=4, DEPTH=64 unless stated)
REQ-032 Fill: RAM[4..7]=0x11,0x22,0x33,0x44, req we=0 addr 0x10 -> ack cycle 0, rvalid cycles 4-7 with 0x11..0x44 in order, done cycle 8.
REQ-033 Writeback: addr 0x20, wdata 0xA0,0xA1,0xA2,0xA3 in cycles 4-7 -> wready cycles 4-7, RAM[8..11]=0xA0..0xA3, done cycle 8.
REQ-034 Alignment/wrap: addr 0x1C fills RAM[4..7]; addr 0x100 fills RAM[0..3].
REQ-035 Reset in cycle 6 of the REQ-033 writeback -> all outputs 0 next cycle, RAM[8..9] written, RAM[10..11] unchanged.
REQ-036 req held high across two transfers -> second ack exactly two cycles after first done; LATENCY=0 -> ack and first rvalid in cycle 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the line-transfer memory responder.
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
package mem_pkg;

    // Transfer phases; every phase except ST_IDLE reports busy.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_LATENCY = 4;   // wait cycles between accept and first beat
    localparam int DEF_BURST   = 4;   // beats per line, power of two
    localparam int DEF_DEPTH   = 64;  // RAM words, power of two

endpackage : mem_pkg

// File: rtl/mem_responder_if.sv
// Cache-to-memory line transfer bus: request/ack, fill beats, writeback beats.
// Latency: n/a (wiring only).
// Backpressure: requester holds req until ack; beats are never stalled.
interface mem_responder_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        rvalid;
    logic [31:0] rdata;
    logic        wready;
    logic        done;
    logic        busy;

    // Cache side issues requests and supplies writeback data.
    modport master (
        output req, we, addr, wdata,
        input  ack, rvalid, rdata, wready, done, busy
    );

    // Memory side accepts requests, returns fill data and consumes writeback data.
    modport slave (
        input  req, we, addr, wdata,
        output ack, rvalid, rdata, wready, done, busy
    );

endinterface : mem_responder_if

// File: rtl/mem_responder.sv
// Line-transfer memory responder: word RAM serving BURST-beat fills and writebacks.
// Latency: ack one cycle after accept, first beat LATENCY cycles after ack's cycle, done after last beat.
// Backpressure: none on beats; new requests only accepted in IDLE, at least one IDLE cycle between transfers.
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int BURST   = DEF_BURST,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int AW = (DEPTH > 1)   ? $clog2(DEPTH)   : 1;
    localparam int BW = (BURST > 1)   ? $clog2(BURST)   : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CW-1:0] WAIT_LOAD  = CW'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST - 1);
    localparam logic [29:0]   ALIGN_MASK = ~30'(BURST - 1);

    // Word-indexed storage; deliberately never reset so the bench can preload it.
    logic [31:0] RAM [DEPTH];

    state_t          state_q, state_d;
    logic            we_q,    we_d;
    logic [AW-1:0]   base_q,  base_d;
    logic [BW-1:0]   beat_q,  beat_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            accept;

    logic [29:0]     line_word;
    logic [AW-1:0]   idx_q, idx_d;
    logic            fill_d, wb_d;

    logic            ack_q, rvalid_q, wready_q, done_q, busy_q;
    logic [31:0]     rdata_q;

    // Byte offset and the word-address bits above the RAM size do not select storage.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[1:0], line_word};

    // Line-aligned word address of the incoming request.
    assign line_word = bus.addr[31:2] & ALIGN_MASK;

    // RAM word for the current and the upcoming beat, wrapping at DEPTH.
    assign idx_q = AW'(32'(base_q) + 32'(beat_q));
    assign idx_d = AW'(32'(base_d) + 32'(beat_d));

    // Next-state and transfer bookkeeping; request inputs only matter in IDLE.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        base_d  = base_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    accept  = 1'b1;
                    we_d    = bus.we;
                    base_d  = line_word[AW-1:0];
                    beat_d  = '0;
                    cnt_d   = WAIT_LOAD;
                    state_d = (LATENCY > 0) ? ST_WAIT : ST_XFER;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_XFER;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_XFER: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = ST_DONE;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    assign fill_d = (state_d == ST_XFER) && !we_d;
    assign wb_d   = (state_d == ST_XFER) &&  we_d;

    // State and transfer context registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            base_q  <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered bus outputs; rdata is forced to zero whenever rvalid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            wready_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ack_q    <= accept;
            rvalid_q <= fill_d;
            rdata_q  <= fill_d ? RAM[idx_d] : '0;
            wready_q <= wb_d;
            done_q   <= (state_d == ST_DONE);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    // Writeback beat lands at the end of its cycle; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == ST_XFER) && we_q) begin
            RAM[idx_q] <= bus.wdata;
        end
    end

    assign bus.ack    = ack_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.wready = wready_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed line transfers plus random ones against a cycle-offset model.
// Latency: checks every cycle from accept through done.
// Backpressure: req held until ack; back-to-back spacing checked.
module tb_mem_responder;

    localparam int L = 4;
    localparam int B = 4;
    localparam int D = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_responder_if ia ();
    mem_responder_if ib ();

    mem_responder #(.LATENCY(L), .BURST(B), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ia)
    );

    mem_responder #(.LATENCY(0), .BURST(B), .DEPTH(D)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (ib)
    );

    logic [31:0] mdl [D];   // expected contents of dut RAM
    logic [31:0] pre [D];   // preload image (dut0 is only ever read)
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RAM word of beat k of a line request at byte address a.
    function automatic int midx(input logic [31:0] a, input int k);
        int w;
        w = int'(a >> 2);
        return ((w / B) * B + k) % D;
    endfunction

    task automatic check_ram(input string tag);
        for (int i = 0; i < D; i++) begin
            chk($sformatf("%s RAM[%0d]", tag, i), dut.RAM[i], mdl[i]);
        end
    endtask

    // One transfer on dut. Returns in the DONE cycle, or in the cycle after a reset
    // asserted during cycle rst_c. wait_n = edges from call to the ack cycle.
    task automatic xfer(input bit wr, input logic [31:0] a, input int rst_c,
                        input bit hold, input bit dir_wd, input int exp_wait);
        int wait_n;
        int k;
        bit in_x;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        ia.req  = 1'b1;
        ia.we   = wr;
        ia.addr = a;
        wait_n  = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ia.ack === 1'b1) begin
                wait_n = i;
                break;
            end
        end
        chk($sformatf("ack wait a=%h", a), 32'(wait_n), 32'(exp_wait));
        if (wait_n == 0) begin
            ia.req = 1'b0;
            return;
        end
        for (int c = 0; c <= L + B; c++) begin
            k    = c - L;
            in_x = (c >= L) && (c < L + B);
            exp_rd = '0;
            if (in_x && !wr) exp_rd = mdl[midx(a, k)];
            chk($sformatf("c%0d ack", c),    32'(ia.ack),    32'(c == 0));
            chk($sformatf("c%0d busy", c),   32'(ia.busy),   32'(1));
            chk($sformatf("c%0d rvalid", c), 32'(ia.rvalid), 32'(in_x && !wr));
            chk($sformatf("c%0d rdata", c),  ia.rdata,       exp_rd);
            chk($sformatf("c%0d wready", c), 32'(ia.wready), 32'(in_x && wr));
            chk($sformatf("c%0d done", c),   32'(ia.done),   32'(c == L + B));
            wd = dir_wd ? (32'hA0 + 32'(k)) : $urandom;
            ia.wdata = wd;
            if (c < L + B) begin
                ia.req  = 1'($urandom_range(0, 1));
                ia.we   = 1'($urandom_range(0, 1));
                ia.addr = $urandom;
            end else begin
                ia.req  = hold;
                ia.we   = wr;
                ia.addr = a;
            end
            if (c == rst_c) begin
                reset = 1'b1;
                tick();
                chk("rst ack",    32'(ia.ack),    32'(0));
                chk("rst busy",   32'(ia.busy),   32'(0));
                chk("rst rvalid", 32'(ia.rvalid), 32'(0));
                chk("rst rdata",  ia.rdata,       32'(0));
                chk("rst wready", 32'(ia.wready), 32'(0));
                chk("rst done",   32'(ia.done),   32'(0));
                reset  = 1'b0;
                ia.req = 1'b0;
                return;
            end
            if (in_x && wr) mdl[midx(a, k)] = wd;
            if (c < L + B) tick();
        end
    endtask

    initial begin
        int ew;
        int rc;
        bit wr;
        logic [31:0] a;
        logic [31:0] v;

        reset = 1'b1;
        ia.req = 1'b0; ia.we = 1'b0; ia.addr = '0; ia.wdata = '0;
        ib.req = 1'b0; ib.we = 1'b0; ib.addr = '0; ib.wdata = '0;
        for (int i = 0; i < D; i++) begin
            v = $urandom;
            if (i >= 4 && i <= 7) v = 32'h11 * 32'(i - 3);
            dut.RAM[i]  = v;
            dut0.RAM[i] = v;
            mdl[i] = v;
            pre[i] = v;
        end
        tick();
        tick();
        chk("reset ack",    32'(ia.ack),    32'(0));
        chk("reset busy",   32'(ia.busy),   32'(0));
        chk("reset rvalid", 32'(ia.rvalid), 32'(0));
        chk("reset rdata",  ia.rdata,       32'(0));
        chk("reset wready", 32'(ia.wready), 32'(0));
        chk("reset done",   32'(ia.done),   32'(0));
        chk("reset0 busy",  32'(ib.busy),   32'(0));
        reset = 1'b0;

        // Fill of line 0x10 returns 0x11..0x44.
        xfer(1'b0, 32'h10, -1, 1'b0, 1'b0, 1);
        // Writeback of line 0x20 with 0xA0..0xA3.
        xfer(1'b1, 32'h20, -1, 1'b0, 1'b1, 2);
        chk("wb RAM[8]",  dut.RAM[8],  32'hA0);
        chk("wb RAM[11]", dut.RAM[11], 32'hA3);
        check_ram("wb");
        // Unaligned address and wrap past DEPTH.
        xfer(1'b0, 32'h1C, -1, 1'b0, 1'b0, 2);
        xfer(1'b0, 32'h100, -1, 1'b0, 1'b0, 2);

        // Reset in cycle 6 of a writeback keeps beats 0,1 only.
        for (int i = 8; i < 12; i++) begin
            dut.RAM[i] = '0;
            mdl[i] = '0;
        end
        xfer(1'b1, 32'h20, 6, 1'b0, 1'b1, 2);
        chk("abort RAM[8]",  dut.RAM[8],  32'hA0);
        chk("abort RAM[9]",  dut.RAM[9],  32'hA1);
        chk("abort RAM[10]", dut.RAM[10], 32'h0);
        chk("abort RAM[11]", dut.RAM[11], 32'h0);

        // req held through DONE: next ack two cycles after done.
        xfer(1'b0, 32'h30, -1, 1'b1, 1'b0, 1);
        xfer(1'b0, 32'h30, -1, 1'b0, 1'b0, 2);

        // Random transfers, some aborted by reset.
        ew = 2;
        for (int t = 0; t < 30; t++) begin
            wr = 1'($urandom_range(0, 1));
            a  = $urandom;
            rc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, L + B)) : -1;
            xfer(wr, a, rc, 1'b0, 1'b0, ew);
            ew = (rc >= 0) ? 1 : 2;
        end
        check_ram("rand");

        // Zero-latency instance: ack and first beat share cycle 0.
        ib.req  = 1'b1;
        ib.we   = 1'b0;
        ib.addr = 32'h44;
        tick();
        ib.req = 1'b0;
        chk("lat0 ack",    32'(ib.ack),    32'(1));
        for (int k = 0; k < B; k++) begin
            if (k > 0) tick();
            chk($sformatf("lat0 b%0d rvalid", k), 32'(ib.rvalid), 32'(1));
            chk($sformatf("lat0 b%0d rdata", k),  ib.rdata,       pre[16 + k]);
        end
        tick();
        chk("lat0 done",   32'(ib.done),   32'(1));
        chk("lat0 rvalid", 32'(ib.rvalid), 32'(0));
        tick();
        chk("lat0 idle",   32'(ib.busy),   32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mem_responder
